// File: rtl/deser_8.sv
// deser_8: serial-to-parallel deserializer. Each accepted serial bit is written
// into slot SEL (or 7-SEL when MSB-first) of an 8-bit assembly register, and
// completed bytes are offered on a valid/ready output port.
// Optional feature macro: DESER8_PARITY_EN adds an even-parity bit after each
// byte, a PARITY state and the sticky PAR_ERR output.
module deser_8 #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SYNC,
  input  logic       IN_VALID,
  input  logic       IN_BIT,
  output logic       IN_READY,
  output logic [7:0] OUT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [2:0] SEL,
  output logic       OVERRUN
`ifdef DESER8_PARITY_EN
  ,
  output logic       PAR_ERR
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] asm_q, asm_d;
  logic [7:0] out_q, out_d;
  logic       out_vld_q, out_vld_d;
  logic       ovr_q, ovr_d;
  logic       perr_q, perr_d;
  logic [2:0] slot;
  logic       accept;
  logic       complete;

  // Bit-slot mapping: the first received bit lands in bit 0 or bit 7
  assign slot   = (LSB_FIRST != 0) ? sel_q : (3'd7 - sel_q);
  // SYNC discards any beat presented in the same cycle
  assign accept = IN_VALID && !rst && !SYNC;

  // State register: all control and data registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      sel_q     <= 3'd0;
      asm_q     <= 8'h00;
      out_q     <= 8'h00;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      asm_q     <= asm_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state logic: slot write, SEL advance, byte completion and hand-off
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    asm_d     = asm_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    ovr_d     = ovr_q;
    perr_d    = perr_q;
    complete  = 1'b0;

    // A consumed byte frees the output unless a new byte arrives below
    if (out_vld_q && OUT_READY) begin
      out_vld_d = 1'b0;
    end

    if (SYNC) begin
      sel_d   = 3'd0;
      asm_d   = 8'h00;
      state_d = COLLECT;
    end else if (accept) begin
      case (state_q)
        COLLECT: begin
          asm_d[slot] = IN_BIT;
          sel_d       = sel_q + 3'd1;
          if (sel_q == 3'd7) begin
`ifdef DESER8_PARITY_EN
            state_d = PARITY;
`else
            complete = 1'b1;
`endif
          end
        end
`ifdef DESER8_PARITY_EN
        PARITY: begin
          // SEL already wrapped to 0 and stays there for the parity beat
          complete = 1'b1;
          state_d  = COLLECT;
          if ((^asm_q) ^ IN_BIT) begin
            perr_d = 1'b1;
          end
        end
`endif
        default: state_d = COLLECT;
      endcase
    end

    // Completed byte: load if the slot is free or being freed, else drop it
    if (complete) begin
      if (!out_vld_q || OUT_READY) begin
        out_d     = asm_d;
        out_vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Output logic: registered values straight to the ports
  always_comb begin
    IN_READY  = !rst;
    OUT       = out_q;
    OUT_VALID = out_vld_q;
    SEL       = sel_q;
    OVERRUN   = ovr_q;
`ifdef DESER8_PARITY_EN
    PAR_ERR   = perr_q;
`endif
  end

`ifndef DESER8_PARITY_EN
  // Parity error register only reaches a port in the parity build
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_deser_8.sv
// tb_deser_8: drives an LSB-first and an MSB-first deser_8 with the same
// stream and compares both against a bit-list reference model every cycle.
module tb_deser_8;

  logic clk = 1'b0;
  logic rst, sync, in_valid, in_bit, out_ready;

  logic       rdy_l, vld_l, ovr_l;
  logic [7:0] out_l;
  logic [2:0] sel_l;
  logic       rdy_m, vld_m, ovr_m;
  logic [7:0] out_m;
  logic [2:0] sel_m;
`ifdef DESER8_PARITY_EN
  logic       perr_l, perr_m;
`endif

  always #5 clk = ~clk;

  deser_8 #(.LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .SYNC(sync), .IN_VALID(in_valid), .IN_BIT(in_bit),
    .IN_READY(rdy_l), .OUT(out_l), .OUT_VALID(vld_l), .OUT_READY(out_ready),
    .SEL(sel_l), .OVERRUN(ovr_l)
`ifdef DESER8_PARITY_EN
    , .PAR_ERR(perr_l)
`endif
  );

  deser_8 #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .SYNC(sync), .IN_VALID(in_valid), .IN_BIT(in_bit),
    .IN_READY(rdy_m), .OUT(out_m), .OUT_VALID(vld_m), .OUT_READY(out_ready),
    .SEL(sel_m), .OVERRUN(ovr_m)
`ifdef DESER8_PARITY_EN
    , .PAR_ERR(perr_m)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of bits received so far in the current frame
  bit       mb[8];
  int       mcnt;
  bit [7:0] mout[2];
  bit       mvld[2];
  bit       movr[2];
  bit       mperr;

  // k = 0: first bit is the LSB; k = 1: first bit is the MSB
  function automatic bit [7:0] compose(input int k);
    bit [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (k == 0) r[i] = mb[i];
      else        r[7 - i] = mb[i];
    end
    return r;
  endfunction

  task automatic model_edge();
    bit done;
    bit px;
    done = 1'b0;
    if (rst) begin
      mcnt  = 0;
      mperr = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mout[k] = 8'h00; mvld[k] = 1'b0; movr[k] = 1'b0;
      end
    end else begin
      if (sync) begin
        mcnt = 0;
      end else if (in_valid) begin
        if (mcnt < 8) begin
          mb[mcnt] = in_bit;
          mcnt++;
`ifndef DESER8_PARITY_EN
          if (mcnt == 8) begin
            done = 1'b1;
            mcnt = 0;
          end
`endif
        end else begin
          px = in_bit;
          for (int i = 0; i < 8; i++) px ^= mb[i];
          if (px) mperr = 1'b1;
          done = 1'b1;
          mcnt = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (done) begin
          if (!mvld[k] || out_ready) begin
            mout[k] = compose(k);
            mvld[k] = 1'b1;
          end else begin
            movr[k] = 1'b1;
          end
        end else if (mvld[k] && out_ready) begin
          mvld[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] esel;
    esel = (mcnt >= 8) ? 3'd0 : 3'(mcnt);
    check("out_l", {24'h0, out_l}, {24'h0, mout[0]});
    check("out_m", {24'h0, out_m}, {24'h0, mout[1]});
    check("vld_l", {31'h0, vld_l}, {31'h0, mvld[0]});
    check("vld_m", {31'h0, vld_m}, {31'h0, mvld[1]});
    check("sel_l", {29'h0, sel_l}, {29'h0, esel});
    check("sel_m", {29'h0, sel_m}, {29'h0, esel});
    check("ovr_l", {31'h0, ovr_l}, {31'h0, movr[0]});
    check("ovr_m", {31'h0, ovr_m}, {31'h0, movr[1]});
    check("rdy_l", {31'h0, rdy_l}, {31'h0, !rst});
    check("rdy_m", {31'h0, rdy_m}, {31'h0, !rst});
`ifdef DESER8_PARITY_EN
    check("perr_l", {31'h0, perr_l}, {31'h0, mperr});
    check("perr_m", {31'h0, perr_m}, {31'h0, mperr});
`endif
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input bit b, input bit ordy);
    rst = r; sync = s; in_valid = v; in_bit = b; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Sends one frame, first bit v[0]; OUT_READY is ordy_last on the final beat
  task automatic send_frame(input bit [7:0] v, input bit par, input bit ordy_body,
                            input bit ordy_last);
`ifdef DESER8_PARITY_EN
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, v[i], ordy_body);
    cycle(1'b0, 1'b0, 1'b1, par, ordy_last);
`else
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, v[i], ordy_body);
    cycle(1'b0, 1'b0, 1'b1, v[7] ^ (par & 1'b0), ordy_last);
`endif
  endtask

  initial begin
    bit r, s, v, b, o;
    rst = 1'b1; sync = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    mcnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("reset_out", {24'h0, out_l}, 32'h0);
    check("reset_sel", {29'h0, sel_l}, 32'h0);

    // Plain byte: stream 1,1,0,0,1,1,0,0
    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    check("plain_lsb", {24'h0, out_l}, 32'h33);
    check("plain_msb", {24'h0, out_m}, 32'hCC);
    check("plain_vld", {31'h0, vld_l}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_vld", {31'h0, vld_l}, 32'h0);

    // Backpressure: second byte dropped
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'hCC, 1'b0, 1'b0, 1'b0);
    check("bp_out", {24'h0, out_l}, 32'h33);
    check("bp_ovr", {31'h0, ovr_l}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drain", {31'h0, vld_l}, 32'h0);

    // Back-to-back with consume on the completion edge
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'hCC, 1'b0, 1'b0, 1'b1);
    check("b2b_out", {24'h0, out_l}, 32'hCC);
    check("b2b_vld", {31'h0, vld_l}, 32'h1);
    check("b2b_ovr", {31'h0, ovr_l}, 32'h0);

    // SYNC after 3 bits, then a full byte
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sync_sel", {29'h0, sel_l}, 32'h0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check("sync_out", {24'h0, out_l}, 32'hA5);

    // Reset mid-byte
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_out", {24'h0, out_l}, 32'h0);
    check("rst_vld", {31'h0, vld_l}, 32'h0);
    check("rst_sel", {29'h0, sel_l}, 32'h0);

`ifdef DESER8_PARITY_EN
    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    check("par_ok", {31'h0, perr_l}, 32'h0);
    send_frame(8'h31, 1'b0, 1'b1, 1'b1);
    check("par_bad", {31'h0, perr_l}, 32'h1);
    check("par_out", {24'h0, out_l}, 32'h31);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom % 200) == 0;
      s = ($urandom % 40) == 0;
      v = ($urandom % 4) != 0;
      b = $urandom % 2;
      o = ($urandom % 3) != 0;
      cycle(r, s, v, b, o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
